ecl_code_sender: RTL and testbench



---
 rtl/ecl_pkg.sv | 22 ++
 rtl/ecl_down_counter.sv | 37 +++
 rtl/ecl_code_sender.sv | 133 +++++++++++++
 tb/tb_ecl_code_sender.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ecl_pkg.sv
// Shared types and defaults for the combination-lock code sender.
package ecl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_WAIT_RESP,
    ST_DONE
  } ecl_state_e;

  localparam int          ECL_DEFAULT_CODE_LEN = 5;
  localparam logic [4:0]  ECL_DEFAULT_CODE     = 5'b01011;
  localparam int          ECL_DEFAULT_GAP      = 2;
  localparam int          ECL_DEFAULT_TIMEOUT  = 8;

  // Width holding 0..max_val; a zero-length interval still gets one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ecl_down_counter.sv
// Loadable saturating down-counter; expired flags the final cycle of the loaded interval.
module ecl_down_counter
  import ecl_pkg::*;
#(
  parameter int MAX = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(MAX);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/ecl_code_sender.sv
// Serialises a stored combination into one-hot button presses, then waits
// a bounded window for the lock's unlock response and reports the result.
module ecl_code_sender
  import ecl_pkg::*;
#(
  parameter int CODE_LEN   = ECL_DEFAULT_CODE_LEN,
  parameter int GAP_CYCLES = ECL_DEFAULT_GAP,
  parameter int TIMEOUT    = ECL_DEFAULT_TIMEOUT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic                abort,
  input  logic [CODE_LEN-1:0] code,
  input  logic                unlock,
  output logic                but_0,
  output logic                but_1,
  output logic                busy,
  output logic                done,
  output logic                success
);

  localparam int PW = cnt_width(CODE_LEN);

  ecl_state_e          state_q, state_d;
  logic [CODE_LEN-1:0] shreg_q, shreg_d;
  logic [PW-1:0]       press_q, press_d;
  logic                success_q, success_d;
  logic                but_0_q, but_0_d, but_1_q, but_1_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                gap_load, gap_dec, gap_exp;
  logic                tmr_load, tmr_dec, tmr_exp;

  ecl_down_counter #(.MAX(GAP_CYCLES)) u_gap (
    .CLK(CLK), .RESET(RESET), .load(gap_load), .dec(gap_dec), .expired(gap_exp)
  );

  ecl_down_counter #(.MAX(TIMEOUT)) u_tmr (
    .CLK(CLK), .RESET(RESET), .load(tmr_load), .dec(tmr_dec), .expired(tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    press_d   = press_q;
    success_d = success_q;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = code;
          press_d   = PW'(CODE_LEN);
          success_d = 1'b0;
          state_d   = ST_PRESS;
        end
      end
      ST_PRESS: begin
        shreg_d = shreg_q << 1;
        press_d = (press_q != '0) ? press_q - PW'(1) : '0;
        if (press_d == '0) begin
          tmr_load = 1'b1;
          state_d  = ST_WAIT_RESP;
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_PRESS;
        end else begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_exp) state_d = ST_PRESS;
      end
      ST_WAIT_RESP: begin
        tmr_dec = 1'b1;
        if (unlock) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end else if (tmr_exp) begin
          success_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      success_d = success_q;
    end

    // Outputs are registered from the upcoming state so a press appears the
    // cycle the FSM sits in PRESS; shreg_d MSB is the bit for that press.
    but_1_d = (state_d == ST_PRESS) &&  shreg_d[CODE_LEN-1];
    but_0_d = (state_d == ST_PRESS) && !shreg_d[CODE_LEN-1];
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      press_q   <= '0;
      success_q <= 1'b0;
      but_0_q   <= 1'b0;
      but_1_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      press_q   <= press_d;
      success_q <= success_d;
      but_0_q   <= but_0_d;
      but_1_q   <= but_1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign but_0   = but_0_q;
  assign but_1   = but_1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign success = success_q;

endmodule

// File: tb/tb_ecl_code_sender.sv
// Bench for ecl_code_sender: default-parameter and zero-gap instances
// checked cycle by cycle against a schedule computed from the timing rules.
module tb_ecl_code_sender;
  import ecl_pkg::*;

  localparam int N = 5;
  localparam int G = ECL_DEFAULT_GAP;
  localparam int T = ECL_DEFAULT_TIMEOUT;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         unlock = 1'b0;
  logic [N-1:0] code = '0;

  logic b0_a, b1_a, busy_a, done_a, succ_a;
  logic b0_z, b1_z, busy_z, done_z, succ_z;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ecl_code_sender #(.CODE_LEN(N), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .code(code),
    .unlock(unlock), .but_0(b0_a), .but_1(b1_a), .busy(busy_a),
    .done(done_a), .success(succ_a)
  );

  ecl_code_sender #(.CODE_LEN(N), .GAP_CYCLES(0), .TIMEOUT(T)) dut0 (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .code(code),
    .unlock(unlock), .but_0(b0_z), .but_1(b1_z), .busy(busy_z),
    .done(done_z), .success(succ_z)
  );

  task automatic check(input string tag, input int cyc, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input bit z, input int cyc, input logic e0, input logic e1,
                            input logic eb, input logic ed, input logic es);
    check("but_0",   cyc, z ? b0_z   : b0_a,   e0);
    check("but_1",   cyc, z ? b1_z   : b1_a,   e1);
    check("busy",    cyc, z ? busy_z : busy_a, eb);
    check("done",    cyc, z ? done_z : done_a, ed);
    check("success", cyc, z ? succ_z : succ_a, es);
  endtask

  // Clears both instances back to IDLE between sequences.
  task automatic flush();
    start = 1'b0; unlock = 1'b0;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    @(posedge CLK); #1;
  endtask

  // u: unlock held high from cycle u (0 = never); a: abort in cycle a (0 = none).
  // noise: random start/code during the run and random unlock before the window.
  task automatic run_seq(input bit z, input logic [N-1:0] c, input int u, input int a,
                         input bit noise);
    int   g, last_p, l_end, first, d_cyc, last, nmax, k;
    bit   succ, stopped, press;
    logic ul [0:63];
    logic e0, e1;
    g      = z ? 0 : G;
    last_p = 1 + (N - 1) * (1 + g);
    l_end  = last_p + T;
    for (int n = 0; n < 64; n++) begin
      if (n <= last_p) ul[n] = noise ? 1'($urandom) : 1'b0;
      else             ul[n] = (u != 0 && n >= u) ? 1'b1 : 1'b0;
    end
    first = 0;
    for (int n = last_p + 1; n <= l_end; n++)
      if (ul[n] && first == 0) first = n;
    succ    = (first != 0);
    d_cyc   = succ ? first + 1 : l_end + 1;
    stopped = (a >= 1 && a < d_cyc);
    last    = stopped ? a : d_cyc;
    nmax    = last + 2;

    start = 1'b1; code = c; abort = 1'b0; unlock = 1'b0;
    @(posedge CLK); #1;
    for (int n = 1; n <= nmax; n++) begin
      if (n <= last) begin
        start  = noise ? ($urandom_range(2) == 0) : 1'b0;
        if (noise) code = N'($urandom);
        unlock = ul[n];
        abort  = (n == a);
      end else begin
        start = 1'b0; unlock = 1'b0; abort = 1'b0;
      end
      k     = (n - 1) / (1 + g);
      press = (n <= last) && ((n - 1) % (1 + g) == 0) && (k < N);
      e1    = press && c[N-1-k];
      e0    = press && !c[N-1-k];
      @(negedge CLK);
      check_outs(z, n, e0, e1, n <= last, !stopped && n == d_cyc,
                 !stopped && succ && n >= d_cyc);
      @(posedge CLK); #1;
    end
    flush();
  endtask

  initial begin
    #2;
    check_outs(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #10 RESET = 1'b1;
    @(posedge CLK); #1;

    // Directed: success at first window cycle, timeout, abort, replay.
    run_seq(1'b0, ECL_DEFAULT_CODE, 14, 0, 1'b0);
    run_seq(1'b0, ECL_DEFAULT_CODE, 0, 0, 1'b0);
    run_seq(1'b0, ECL_DEFAULT_CODE, 0, 5, 1'b0);
    run_seq(1'b0, ECL_DEFAULT_CODE, 21, 0, 1'b0);
    run_seq(1'b0, ECL_DEFAULT_CODE, 22, 0, 1'b0);
    run_seq(1'b0, ECL_DEFAULT_CODE, 16, 0, 1'b1);

    // Zero gap: back-to-back presses.
    run_seq(1'b1, 5'b10000, 9, 0, 1'b0);
    run_seq(1'b1, 5'b10000, 0, 0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      bit           zz;
      logic [N-1:0] cr;
      int           lp, ur, ar;
      zz = 1'($urandom);
      cr = N'($urandom);
      lp = 1 + (N - 1) * (1 + (zz ? 0 : G));
      ur = ($urandom_range(3) == 0) ? 0 : lp + 1 + int'($urandom_range(T));
      ar = ($urandom_range(2) == 0) ? 1 + int'($urandom_range(lp)) : 0;
      run_seq(zz, cr, ur, ar, 1'b1);
    end

    // Asynchronous reset during a press.
    start = 1'b1; code = ECL_DEFAULT_CODE;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    check("rst_press_seen", 4, b1_a, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check_outs(1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check_outs(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    run_seq(1'b0, ECL_DEFAULT_CODE, 18, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
